// File: rtl/cfg_list_loader.sv
// Buffers a header+payload configuration list in a small FIFO and replays the
// payload as register writes to consecutive addresses over a req/ack port.
module cfg_list_loader #(
    parameter int DW         = 32,
    parameter int AW         = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_LEN    = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          wr_req,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    input  logic          wr_ack,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   wr_count
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, SKIP, DRAIN, FIN} state_t;
    state_t state, stateNext;

    logic [DW-1:0] fifoMem [FIFO_DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [PW:0]   fifoCount;
    logic          fifoFull, fifoEmpty;

    logic [AW-1:0] baseAddr, wrIdx, hdrBase;
    logic [15:0]   listLen, payloadIdx, hdrLen;
    logic          errPulse, readyComb;
    logic          accept, headerAccept, push, pop, lastPayload;

    assign hdrLen  = s_data[15:0];
    assign hdrBase = AW'(s_data[31:16]);

    assign fifoFull  = (fifoCount == (PW+1)'(FIFO_DEPTH));
    assign fifoEmpty = (fifoCount == '0);

    // Ready is held low during reset so no word slips in before the FSM is defined.
    always_comb begin
        readyComb = 1'b0;
        unique case (state)
            IDLE, SKIP: readyComb = 1'b1;
            LOAD:       readyComb = !fifoFull;
            default:    readyComb = 1'b0;
        endcase
    end

    assign s_ready      = !rst && readyComb;
    assign accept       = s_valid && s_ready;
    assign headerAccept = accept && (state == IDLE);
    assign push         = accept && (state == LOAD);
    assign lastPayload  = (payloadIdx == listLen - 16'd1);

    assign wr_req  = ((state == LOAD) || (state == DRAIN)) && !fifoEmpty;
    assign wr_data = wr_req ? fifoMem[rdPtr] : '0;
    assign wr_addr = baseAddr + wrIdx;
    assign pop     = wr_req && wr_ack;

    assign busy = (state != IDLE);
    assign done = (state == FIN);
    assign err  = errPulse;

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (headerAccept) begin
                    if (hdrLen == 16'd0)                 stateNext = FIN;
                    else if (hdrLen > 16'(MAX_LEN))      stateNext = SKIP;
                    else                                 stateNext = LOAD;
                end
            end
            LOAD:  if (push && lastPayload)   stateNext = DRAIN;
            SKIP:  if (accept && lastPayload) stateNext = IDLE;
            // The final ack retires the last entry, so finishing on it saves a cycle.
            DRAIN: if (fifoEmpty || ((fifoCount == (PW+1)'(1)) && pop)) stateNext = FIN;
            FIN:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wrPtr      <= '0;
            rdPtr      <= '0;
            fifoCount  <= '0;
            baseAddr   <= '0;
            wrIdx      <= '0;
            listLen    <= '0;
            payloadIdx <= '0;
            wr_count   <= '0;
            errPulse   <= 1'b0;
        end else begin
            state    <= stateNext;
            errPulse <= headerAccept && (hdrLen > 16'(MAX_LEN));
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
            if (headerAccept) begin
                baseAddr   <= hdrBase;
                listLen    <= hdrLen;
                payloadIdx <= '0;
                wrIdx      <= '0;
                wr_count   <= '0;
            end else begin
                if (push || (accept && (state == SKIP))) payloadIdx <= payloadIdx + 16'd1;
                if (pop) begin
                    wrIdx    <= wrIdx + 1'b1;
                    wr_count <= wr_count + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= s_data;
    end

endmodule

// File: tb/tb_cfg_list_loader.sv
// Bench for cfg_list_loader: directed and randomized lists checked against a
// queue of expected (address, data) writes derived from each header and payload.
module tb_cfg_list_loader;
    localparam int MAX_LEN = 256;

    logic        clk, rst, s_valid, s_ready, wr_req, wr_ack, busy, done, err;
    logic [31:0] s_data, wr_data;
    logic [15:0] wr_addr, wr_count;

    cfg_list_loader #(.DW(32), .AW(16), .FIFO_DEPTH(8), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .busy(busy), .done(done), .err(err), .wr_count(wr_count)
    );

    typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;
    wr_t         expQ[$];
    logic [31:0] pay[$];
    int          wrCyc[$];
    int checks = 0, errors = 0, cyc = 0, nDone = 0, nErr = 0, expDone = 0, expErr = 0;
    int doneCyc = -1, acceptCyc = 0, idleCyc = 0, ackMode = 0;
    logic        idleReady;
    logic        pend = 1'b0;
    logic [15:0] pAddr;
    logic [31:0] pData;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write acceptor: constant low, constant high, or random (also while wr_req=0).
    initial begin
        wr_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ackMode)
                0:       wr_ack = 1'b0;
                1:       wr_ack = 1'b1;
                default: wr_ack = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every acked write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend)
                chk("write held stable", {wr_req, wr_addr, wr_data}, {1'b1, pAddr, pData});
            if (wr_req && wr_ack) begin
                chk("write was expected", expQ.size() != 0, 1'b1);
                if (expQ.size() != 0) begin
                    chk("write addr/data", {wr_addr, wr_data}, {expQ[0].a, expQ[0].d});
                    void'(expQ.pop_front());
                end
                wrCyc.push_back(cyc);
            end
            pend  = wr_req && !wr_ack;
            pAddr = wr_addr;
            pData = wr_data;
            if (done) begin nDone++; doneCyc = cyc; end
            if (err) nErr++;
        end
    end

    task automatic randPay(input int len);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back($urandom);
    endtask

    task automatic expectList(input logic [15:0] base, input int len);
        logic [15:0] a;
        if (len == 0) expDone++;
        else if (len > MAX_LEN) expErr++;
        else begin
            for (int i = 0; i < len; i++) begin
                a = base + 16'(i);
                expQ.push_back('{a: a, d: pay[i]});
            end
            expDone++;
        end
    endtask

    task automatic sendWord(input logic [31:0] w, input bit gaps);
        int   n   = 0;
        logic acc = 1'b0;
        s_valid = 1'b1;
        s_data  = w;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = s_ready;
            if (acc) acceptCyc = cyc;
            @(posedge clk); #1;
            n++;
        end
        s_valid = 1'b0;
        chk("stream word accepted", acc, 1'b1);
        if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    endtask

    task automatic sendList(input logic [15:0] base, input int len, input bit gaps);
        expectList(base, len);
        sendWord({base, 16'(len)}, gaps);
        for (int i = 0; i < len; i++) sendWord(pay[i], gaps);
    endtask

    task automatic waitIdle();
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((expQ.size() != 0 || busy) && n < 3000);
        chk("list completes in budget", n < 3000, 1'b1);
        idleCyc   = cyc;
        idleReady = s_ready;
        @(posedge clk); #1;
    endtask

    task automatic setAck(input int m);
        @(negedge clk);
        ackMode = m;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] b;
        int h, k, n, d0, len;
        rst = 1'b1; s_valid = 1'b0; s_data = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset s_ready", s_ready, 1'b0);
        chk("reset wr_req", wr_req, 1'b0);
        chk("reset wr_addr", wr_addr, 16'h0);
        chk("reset wr_data", wr_data, 32'h0);
        chk("reset busy/done/err", {busy, done, err}, 3'b000);
        chk("reset wr_count", wr_count, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("s_ready after reset", s_ready, 1'b1);
        @(posedge clk); #1;

        // Three-word list, ack tied high: back-to-back writes, done right after
        setAck(1);
        wrCyc.delete();
        d0 = nDone;
        pay = {32'hA, 32'hB, 32'hC};
        expectList(16'h0100, 3);
        sendWord({16'h0100, 16'd3}, 1'b0);
        h = acceptCyc;
        for (int i = 0; i < 3; i++) sendWord(pay[i], 1'b0);
        waitIdle();
        chk("t1 write count", wrCyc.size(), 3);
        chk("t1 write cycle 0", wrCyc.size() > 0 ? wrCyc[0] : -1, h + 2);
        chk("t1 write cycle 2", wrCyc.size() > 2 ? wrCyc[2] : -1, h + 4);
        chk("t1 done cycle", doneCyc, h + 5);
        chk("t1 single done", nDone - d0, 1);
        chk("t1 wr_count", wr_count, 16'd3);
        chk("t1 idle cycle", idleCyc, h + 6);
        chk("t1 s_ready when idle", idleReady, 1'b1);

        // Back-pressure: ack low, stream stalls after FIFO_DEPTH pushes
        setAck(0);
        b = 16'($urandom);
        randPay(20);
        expectList(b, 20);
        sendWord({b, 16'd20}, 1'b0);
        k = 0;
        for (int c = 0; c < 30; c++) begin
            s_valid = 1'b1;
            s_data  = pay[k];
            @(negedge clk);
            if (s_ready && k < 19) k++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t2 s_ready low when full", s_ready, 1'b0);
        ackMode = 1;
        @(posedge clk); #1;
        chk("t2 pushes before stall", k, 8);
        for (int i = k; i < 20; i++) sendWord(pay[i], 1'b0);
        waitIdle();
        chk("t2 wr_count", wr_count, 16'd20);

        // Empty list: done in cycle 1, ready again in cycle 2
        setAck(2);
        sendList(16'h0042, 0, 1'b0);
        @(negedge clk);
        chk("t3 done cycle 1", {done, wr_req}, 2'b10);
        @(negedge clk);
        chk("t3 ready cycle 2", {done, s_ready, busy}, 3'b010);
        @(posedge clk); #1;

        // Oversize list is skipped with one err pulse, then a normal list follows
        randPay(300);
        expectList(16'h1234, 300);
        sendWord({16'h1234, 16'd300}, 1'b0);
        @(negedge clk);
        chk("t4 err pulse", {err, busy}, 2'b11);
        @(posedge clk); #1;
        for (int i = 0; i < 300; i++) sendWord(pay[i], 1'b1);
        @(negedge clk);
        chk("t4 idle after skip", {busy, err}, 2'b00);
        @(posedge clk); #1;
        pay = {32'h5};
        sendList(16'h0010, 1, 1'b0);
        waitIdle();
        chk("t4 wr_count", wr_count, 16'd1);

        // Address wrap at top of space
        randPay(4);
        sendList(16'hFFFE, 4, 1'b1);
        waitIdle();
        chk("t5 wr_count", wr_count, 16'd4);

        // Randomized lists including the MAX_LEN boundary and MAX_LEN+1
        for (int t = 0; t < 8; t++) begin
            len = (t == 6) ? MAX_LEN : (t == 7) ? MAX_LEN + 1 : int'($urandom_range(1, 40));
            b = 16'($urandom);
            randPay(len);
            sendList(b, len, 1'b1);
            waitIdle();
            if (len <= MAX_LEN) chk("random wr_count", wr_count, 16'(len));
        end

        // Reset in the middle of a list
        setAck(0);
        d0 = nDone;
        b = 16'($urandom);
        randPay(5);
        expectList(b, 5);
        expDone--;
        sendWord({b, 16'd5}, 1'b0);
        for (int i = 0; i < 5; i++) sendWord(pay[i], 1'b0);
        @(negedge clk);
        ackMode = 1;
        k = 0; n = 0;
        while (k < 2 && n < 50) begin
            @(negedge clk);
            if (wr_req && wr_ack) k++;
            n++;
        end
        ackMode = 0;
        chk("t6 two acks seen", k, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        chk("t6 rst s_ready/wr_req", {s_ready, wr_req}, 2'b00);
        chk("t6 rst wr_addr/wr_data", {wr_addr, wr_data}, 48'h0);
        chk("t6 rst busy/done/err", {busy, done, err}, 3'b000);
        chk("t6 rst wr_count", wr_count, 16'h0);
        chk("t6 writes dropped", expQ.size(), 3);
        expQ.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6 ready after reset", {s_ready, busy}, 2'b10);
        @(posedge clk); #1;
        chk("t6 no done on reset", nDone - d0, 0);
        setAck(1);
        pay = {32'h600D_CAFE};
        sendList(16'h0200, 1, 1'b0);
        waitIdle();
        chk("t6 restart wr_count", wr_count, 16'd1);

        chk("total done pulses", nDone, expDone);
        chk("total err pulses", nErr, expErr);
        chk("no writes outstanding", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
